// File: rtl/lsq_sequencer_if.sv
// Bundles the dispatch, commit, data-memory and writeback signals of lsq_sequencer.
// The slave modport is the queue side; the master modport is everything around it.
interface lsq_sequencer_if #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             enq_valid;
  logic             enq_ready;
  logic             enq_is_load;
  logic [2:0]       enq_func3;
  logic [XLEN-1:0]  enq_base;
  logic [XLEN-1:0]  enq_imm;
  logic [XLEN-1:0]  enq_sdata;
  logic [TAG_W-1:0] enq_tag;
  logic             flush;
  logic             commit_valid;
  logic [TAG_W-1:0] commit_tag;
  logic             mem_read;
  logic             mem_write;
  logic [XLEN-1:0]  mem_addr;
  logic [2:0]       mem_func3;
  logic [XLEN-1:0]  mem_wdata;
  logic             mem_hit;
  logic [XLEN-1:0]  mem_rdata;
  logic             wb_valid;
  logic             wb_ready;
  logic [XLEN-1:0]  wb_data;
  logic [TAG_W-1:0] wb_tag;
  logic [CNT_W-1:0] count;

  modport slave (
    input  enq_valid, enq_is_load, enq_func3, enq_base, enq_imm, enq_sdata, enq_tag,
    input  flush, commit_valid, commit_tag, mem_hit, mem_rdata, wb_ready,
    output enq_ready, mem_read, mem_write, mem_addr, mem_func3, mem_wdata,
    output wb_valid, wb_data, wb_tag, count
  );

  modport master (
    output enq_valid, enq_is_load, enq_func3, enq_base, enq_imm, enq_sdata, enq_tag,
    output flush, commit_valid, commit_tag, mem_hit, mem_rdata, wb_ready,
    input  enq_ready, mem_read, mem_write, mem_addr, mem_func3, mem_wdata,
    input  wb_valid, wb_data, wb_tag, count
  );
endinterface

// File: rtl/lsq_sequencer.sv
// In-order load/store queue: one memory access at a time, loads written back with extension,
// stores held until ROB commit. Define LSQ_PERF_CNT_EN to add miss/load performance counters.
module lsq_sequencer #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic clock,
  input  logic reset_n,
  lsq_sequencer_if.slave bus
`ifdef LSQ_PERF_CNT_EN
  ,
  output logic [15:0] perf_miss_cnt,
  output logic [15:0] perf_load_cnt
`endif
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef struct packed {
    logic             is_load;
    logic [2:0]       func3;
    logic [XLEN-1:0]  addr;
    logic [XLEN-1:0]  sdata;
    logic [TAG_W-1:0] tag;
  } entry_t;

  typedef enum logic [1:0] {IDLE, SWAIT, ACCESS, WB} state_t;

  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_head, r_tail;
  logic [CNT_W-1:0] r_count;
  state_t           r_state;
  logic             r_mem_read, r_mem_write;
  logic [XLEN-1:0]  r_mem_addr, r_mem_wdata;
  logic [2:0]       r_mem_func3;
  logic             r_wb_valid;
  logic [XLEN-1:0]  r_wb_data;
  logic [TAG_W-1:0] r_wb_tag;

  entry_t w_head, w_new;
  logic   w_enq, w_deq, w_commit, w_issue, w_enq_ready;

  function automatic logic [XLEN-1:0] f_extend(input logic [2:0] f3, input logic [1:0] lane,
                                               input logic [XLEN-1:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[{lane, 3'b000} +: 8];
    h = d[{lane[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  f_extend = {{(XLEN-8){b[7]}}, b};
      3'b100:  f_extend = {{(XLEN-8){1'b0}}, b};
      3'b001:  f_extend = {{(XLEN-16){h[15]}}, h};
      3'b101:  f_extend = {{(XLEN-16){1'b0}}, h};
      default: f_extend = d;
    endcase
  endfunction

  assign w_head      = r_mem[r_head];
  assign w_new       = {bus.enq_is_load, bus.enq_func3, bus.enq_base + bus.enq_imm,
                        bus.enq_sdata, bus.enq_tag};
  assign w_enq_ready = r_count < FULL;
  assign w_enq       = bus.enq_valid && w_enq_ready && !bus.flush;
  assign w_commit    = bus.commit_valid && (bus.commit_tag == w_head.tag);
  assign w_deq       = (r_state == ACCESS && bus.mem_hit && !w_head.is_load) ||
                       (r_state == WB && bus.wb_ready);

  // A store whose commit coincides with reaching the head issues without a wait cycle.
  always_comb begin
    w_issue = 1'b0;
    case (r_state)
      IDLE:    w_issue = (r_count != '0) && (w_head.is_load || w_commit);
      SWAIT:   w_issue = w_commit;
      default: w_issue = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (w_enq) r_mem[r_tail] <= w_new;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_state     <= IDLE;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_func3 <= '0;
      r_mem_wdata <= '0;
      r_wb_valid  <= 1'b0;
      r_wb_data   <= '0;
      r_wb_tag    <= '0;
    end else if (bus.flush) begin
      // An in-flight store is already committed, so it survives the squash.
      if (r_state == ACCESS && !w_head.is_load) begin
        r_tail <= r_head + PTR_W'(1);
        if (bus.mem_hit) begin
          r_head      <= r_head + PTR_W'(1);
          r_count     <= '0;
          r_state     <= IDLE;
          r_mem_write <= 1'b0;
          r_mem_wdata <= '0;
        end else begin
          r_count <= CNT_W'(1);
        end
      end else begin
        r_tail      <= r_head;
        r_count     <= '0;
        r_state     <= IDLE;
        r_mem_read  <= 1'b0;
        r_mem_write <= 1'b0;
        r_wb_valid  <= 1'b0;
      end
    end else begin
      if (w_enq) r_tail <= r_tail + PTR_W'(1);
      if (w_deq) r_head <= r_head + PTR_W'(1);
      if (w_enq && !w_deq)      r_count <= r_count + CNT_W'(1);
      else if (!w_enq && w_deq) r_count <= r_count - CNT_W'(1);

      case (r_state)
        IDLE, SWAIT: begin
          if (w_issue) begin
            r_state     <= ACCESS;
            r_mem_read  <= w_head.is_load;
            r_mem_write <= !w_head.is_load;
            r_mem_addr  <= w_head.addr;
            r_mem_func3 <= w_head.func3;
            r_mem_wdata <= w_head.is_load ? '0 : w_head.sdata;
          end else if (r_state == IDLE && r_count != '0) begin
            r_state <= SWAIT;
          end
        end
        ACCESS: begin
          if (bus.mem_hit) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_wdata <= '0;
            if (w_head.is_load) begin
              r_wb_valid <= 1'b1;
              r_wb_data  <= f_extend(w_head.func3, w_head.addr[1:0], bus.mem_rdata);
              r_wb_tag   <= w_head.tag;
              r_state    <= WB;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        WB: begin
          if (bus.wb_ready) begin
            r_wb_valid <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.enq_ready = w_enq_ready;
  assign bus.mem_read  = r_mem_read;
  assign bus.mem_write = r_mem_write;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_func3 = r_mem_func3;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.wb_valid  = r_wb_valid;
  assign bus.wb_data   = r_wb_data;
  assign bus.wb_tag    = r_wb_tag;
  assign bus.count     = r_count;

`ifdef LSQ_PERF_CNT_EN
  logic [15:0] r_perf_miss, r_perf_load;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_perf_miss <= '0;
      r_perf_load <= '0;
    end else begin
      if (r_state == ACCESS && !bus.mem_hit && r_perf_miss != 16'hFFFF)
        r_perf_miss <= r_perf_miss + 16'd1;
      if (r_state == WB && bus.wb_ready && r_perf_load != 16'hFFFF)
        r_perf_load <= r_perf_load + 16'd1;
    end
  end

  assign perf_miss_cnt = r_perf_miss;
  assign perf_load_cnt = r_perf_load;
`endif
endmodule

// File: tb/tb_lsq_sequencer.sv
// Directed self-checking bench for lsq_sequencer.
module tb_lsq_sequencer;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  lsq_sequencer_if #(.DEPTH(4), .XLEN(32), .TAG_W(5)) bus ();

`ifdef LSQ_PERF_CNT_EN
  logic [15:0] perf_miss_cnt, perf_load_cnt;
  lsq_sequencer #(.DEPTH(4), .XLEN(32), .TAG_W(5)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus),
    .perf_miss_cnt(perf_miss_cnt), .perf_load_cnt(perf_load_cnt));
`else
  lsq_sequencer #(.DEPTH(4), .XLEN(32), .TAG_W(5)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus));
`endif

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.enq_valid = 0; bus.enq_is_load = 0; bus.enq_func3 = 0; bus.enq_base = 0;
    bus.enq_imm = 0; bus.enq_sdata = 0; bus.enq_tag = 0; bus.flush = 0;
    bus.commit_valid = 0; bus.commit_tag = 0; bus.mem_hit = 0; bus.mem_rdata = 0;
    bus.wb_ready = 0;
  endtask

  task automatic set_enq(input logic ld, input logic [2:0] f3, input logic [31:0] base,
                         input logic [31:0] imm, input logic [31:0] sd, input logic [4:0] tag);
    bus.enq_valid = 1; bus.enq_is_load = ld; bus.enq_func3 = f3; bus.enq_base = base;
    bus.enq_imm = imm; bus.enq_sdata = sd; bus.enq_tag = tag;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 0;
    #12;
    n_tests++; if (bus.count !== 3'd0) begin n_fail++; $display("FAIL rst_count got=%0d exp=0", bus.count); end
    n_tests++; if (bus.enq_ready !== 1'b1) begin n_fail++; $display("FAIL rst_enq_ready got=%b exp=1", bus.enq_ready); end
    n_tests++; if ({bus.mem_read, bus.mem_write, bus.wb_valid} !== 3'b000) begin n_fail++; $display("FAIL rst_ctrl got=%b exp=000", {bus.mem_read, bus.mem_write, bus.wb_valid}); end
    n_tests++; if ({bus.mem_addr, bus.mem_wdata, bus.wb_data, bus.wb_tag, bus.mem_func3} !== '0) begin n_fail++; $display("FAIL rst_data got=%h exp=0", {bus.mem_addr, bus.mem_wdata, bus.wb_data}); end
    @(negedge clock);
    reset_n = 1;
    tick();
  endtask

  task automatic test_load_byte();
    set_enq(1, 3'b000, 32'h1000, 32'h3, 32'h0, 5'd5);
    tick();
    bus.enq_valid = 0;
    n_tests++; if (bus.count !== 3'd1 || bus.mem_read !== 1'b0) begin n_fail++; $display("FAIL lb_idle count=%0d rd=%b exp 1/0", bus.count, bus.mem_read); end
    tick();
    n_tests++; if (bus.mem_read !== 1'b1 || bus.mem_write !== 1'b0) begin n_fail++; $display("FAIL lb_rd got rd=%b wr=%b exp 1/0", bus.mem_read, bus.mem_write); end
    n_tests++; if (bus.mem_addr !== 32'h1003 || bus.mem_func3 !== 3'b000 || bus.mem_wdata !== 32'h0) begin n_fail++; $display("FAIL lb_addr got=%h f3=%0d wd=%h exp 1003/0/0", bus.mem_addr, bus.mem_func3, bus.mem_wdata); end
    bus.mem_hit = 1; bus.mem_rdata = 32'h8000_0000;
    tick();
    bus.mem_hit = 0;
    n_tests++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'hFFFF_FF80 || bus.wb_tag !== 5'd5) begin n_fail++; $display("FAIL lb_wb got v=%b d=%h t=%0d exp 1/ffffff80/5", bus.wb_valid, bus.wb_data, bus.wb_tag); end
    n_tests++; if (bus.mem_read !== 1'b0) begin n_fail++; $display("FAIL lb_rd_drop got=%b exp=0", bus.mem_read); end
    bus.wb_ready = 1;
    tick();
    bus.wb_ready = 0;
    n_tests++; if (bus.wb_valid !== 1'b0 || bus.count !== 3'd0) begin n_fail++; $display("FAIL lb_deq got v=%b count=%0d exp 0/0", bus.wb_valid, bus.count); end
  endtask

  task automatic test_load_retry();
    int rd_cycles = 0;
`ifdef LSQ_PERF_CNT_EN
    logic [15:0] miss0 = perf_miss_cnt, load0 = perf_load_cnt;
`endif
    set_enq(1, 3'b100, 32'h1000, 32'h3, 32'h0, 5'd6);
    tick();
    bus.enq_valid = 0;
    bus.mem_rdata = 32'h8000_0000;
    tick();
    for (int i = 0; i < 4; i++) begin
      if (bus.mem_read === 1'b1) rd_cycles++;
      if (i == 3) bus.mem_hit = 1;
      tick();
      bus.mem_hit = 0;
    end
    n_tests++; if (rd_cycles != 4) begin n_fail++; $display("FAIL retry_rd_cycles got=%0d exp=4", rd_cycles); end
    n_tests++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'h0000_0080 || bus.wb_tag !== 5'd6) begin n_fail++; $display("FAIL retry_wb got v=%b d=%h t=%0d exp 1/00000080/6", bus.wb_valid, bus.wb_data, bus.wb_tag); end
    bus.wb_ready = 1;
    tick();
    bus.wb_ready = 0;
`ifdef LSQ_PERF_CNT_EN
    n_tests++; if (perf_miss_cnt - miss0 !== 16'd3 || perf_load_cnt - load0 !== 16'd1) begin n_fail++; $display("FAIL perf got miss+%0d load+%0d exp 3/1", perf_miss_cnt - miss0, perf_load_cnt - load0); end
`endif
  endtask

  task automatic test_store_commit();
    int early_wr = 0;
    set_enq(0, 3'b010, 32'h2000, 32'h4, 32'hDEAD_BEEF, 5'd7);
    tick();
    bus.enq_valid = 0;
    tick();
    bus.commit_valid = 1; bus.commit_tag = 5'd3;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.mem_write !== 1'b0 || bus.wb_valid !== 1'b0) early_wr++;
    end
    n_tests++; if (early_wr != 0) begin n_fail++; $display("FAIL st_wait_write got=%0d cycles exp=0", early_wr); end
    bus.commit_tag = 5'd7;
    tick();
    bus.commit_valid = 0;
    n_tests++; if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0) begin n_fail++; $display("FAIL st_issue got wr=%b rd=%b exp 1/0", bus.mem_write, bus.mem_read); end
    n_tests++; if (bus.mem_addr !== 32'h2004 || bus.mem_wdata !== 32'hDEAD_BEEF || bus.mem_func3 !== 3'b010) begin n_fail++; $display("FAIL st_bus got a=%h d=%h f3=%0d exp 2004/deadbeef/2", bus.mem_addr, bus.mem_wdata, bus.mem_func3); end
    bus.mem_hit = 1;
    tick();
    bus.mem_hit = 0;
    n_tests++; if (bus.mem_write !== 1'b0 || bus.count !== 3'd0 || bus.wb_valid !== 1'b0) begin n_fail++; $display("FAIL st_done got wr=%b count=%0d wbv=%b exp 0/0/0", bus.mem_write, bus.count, bus.wb_valid); end
  endtask

  task automatic test_full_wrap();
    logic [4:0]  exp_tag [3] = '{5'd12, 5'd13, 5'd14};
    logic [31:0] exp_adr [3] = '{32'h300, 32'h400, 32'h500};
    for (int k = 0; k < 4; k++) begin
      set_enq(0, 3'b010, 32'h100 * (k + 1), 32'h0, 32'hC0 + k, 5'(10 + k));
      tick();
    end
    n_tests++; if (bus.count !== 3'd4 || bus.enq_ready !== 1'b0) begin n_fail++; $display("FAIL full got count=%0d rdy=%b exp 4/0", bus.count, bus.enq_ready); end
    set_enq(0, 3'b010, 32'h999, 32'h0, 32'h0, 5'd31);
    bus.commit_valid = 1; bus.commit_tag = 5'd10;
    tick();
    bus.commit_valid = 0;
    n_tests++; if (bus.mem_addr !== 32'h100 || bus.count !== 3'd4) begin n_fail++; $display("FAIL full_s0 got a=%h count=%0d exp 100/4", bus.mem_addr, bus.count); end
    bus.mem_hit = 1;
    tick();
    bus.mem_hit = 0; bus.enq_valid = 0;
    n_tests++; if (bus.count !== 3'd3) begin n_fail++; $display("FAIL full_reject got count=%0d exp=3", bus.count); end
    bus.commit_valid = 1; bus.commit_tag = 5'd11;
    tick();
    bus.commit_valid = 0;
    n_tests++; if (bus.mem_addr !== 32'h200 || bus.mem_write !== 1'b1) begin n_fail++; $display("FAIL full_s1 got a=%h wr=%b exp 200/1", bus.mem_addr, bus.mem_write); end
    set_enq(0, 3'b010, 32'h500, 32'h0, 32'hC4, 5'd14);
    bus.mem_hit = 1;
    tick();
    bus.mem_hit = 0; bus.enq_valid = 0;
    n_tests++; if (bus.count !== 3'd3) begin n_fail++; $display("FAIL enq_deq_same got count=%0d exp=3", bus.count); end
    for (int k = 0; k < 3; k++) begin
      bus.commit_valid = 1; bus.commit_tag = exp_tag[k];
      tick();
      bus.commit_valid = 0;
      n_tests++; if (bus.mem_write !== 1'b1 || bus.mem_addr !== exp_adr[k]) begin n_fail++; $display("FAIL wrap_order[%0d] got wr=%b a=%h exp 1/%h", k, bus.mem_write, bus.mem_addr, exp_adr[k]); end
      bus.mem_hit = 1;
      tick();
      bus.mem_hit = 0;
    end
    n_tests++; if (bus.count !== 3'd0) begin n_fail++; $display("FAIL wrap_drain got count=%0d exp=0", bus.count); end
  endtask

  task automatic test_wb_stall();
    int unstable = 0;
    set_enq(1, 3'b101, 32'h80, 32'h2, 32'h0, 5'd24);
    tick();
    set_enq(1, 3'b001, 32'h90, 32'h0, 32'h0, 5'd25);
    tick();
    bus.enq_valid = 0;
    bus.mem_hit = 1; bus.mem_rdata = 32'hA5A5_0000;
    tick();
    bus.mem_hit = 0; bus.mem_rdata = 32'h0000_8001;
    for (int i = 0; i < 4; i++) begin
      if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'h0000_A5A5 || bus.wb_tag !== 5'd24 || bus.mem_read !== 1'b0) unstable++;
      tick();
    end
    n_tests++; if (unstable != 0) begin n_fail++; $display("FAIL wb_stall got %0d bad cycles exp=0 (d=%h)", unstable, bus.wb_data); end
    bus.wb_ready = 1;
    tick();
    bus.wb_ready = 0;
    n_tests++; if (bus.wb_valid !== 1'b0 || bus.count !== 3'd1) begin n_fail++; $display("FAIL wb_release got v=%b count=%0d exp 0/1", bus.wb_valid, bus.count); end
    tick();
    n_tests++; if (bus.mem_read !== 1'b1 || bus.mem_addr !== 32'h90) begin n_fail++; $display("FAIL next_load got rd=%b a=%h exp 1/90", bus.mem_read, bus.mem_addr); end
    bus.mem_hit = 1;
    tick();
    bus.mem_hit = 0;
    n_tests++; if (bus.wb_data !== 32'hFFFF_8001 || bus.wb_tag !== 5'd25) begin n_fail++; $display("FAIL lh_ext got d=%h t=%0d exp ffff8001/25", bus.wb_data, bus.wb_tag); end
    bus.wb_ready = 1;
    tick();
    bus.wb_ready = 0;
  endtask

  task automatic test_flush_wb();
    int stray = 0;
    set_enq(1, 3'b010, 32'h40, 32'h0, 32'h0, 5'd20);
    tick();
    set_enq(1, 3'b010, 32'h44, 32'h0, 32'h0, 5'd21);
    tick();
    set_enq(1, 3'b010, 32'h48, 32'h0, 32'h0, 5'd22);
    bus.mem_hit = 1; bus.mem_rdata = 32'h1234_5678;
    tick();
    bus.mem_hit = 0;
    set_enq(1, 3'b010, 32'h4C, 32'h0, 32'h0, 5'd23);
    tick();
    bus.enq_valid = 0;
    n_tests++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'h1234_5678 || bus.count !== 3'd4) begin n_fail++; $display("FAIL flwb_pre got v=%b d=%h count=%0d exp 1/12345678/4", bus.wb_valid, bus.wb_data, bus.count); end
    bus.flush = 1;
    set_enq(1, 3'b010, 32'h50, 32'h0, 32'h0, 5'd26);
    tick();
    bus.flush = 0; bus.enq_valid = 0;
    n_tests++; if (bus.count !== 3'd0 || bus.wb_valid !== 1'b0) begin n_fail++; $display("FAIL flwb got count=%0d v=%b exp 0/0", bus.count, bus.wb_valid); end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.mem_read !== 1'b0 || bus.count !== 3'd0) stray++;
    end
    n_tests++; if (stray != 0) begin n_fail++; $display("FAIL flwb_quiet got %0d busy cycles exp=0", stray); end
  endtask

  task automatic test_flush_store();
    int stray = 0;
    set_enq(0, 3'b010, 32'h700, 32'h0, 32'h11, 5'd30);
    tick();
    set_enq(1, 3'b010, 32'h704, 32'h0, 32'h0, 5'd31);
    tick();
    set_enq(1, 3'b010, 32'h708, 32'h0, 32'h0, 5'd1);
    bus.commit_valid = 1; bus.commit_tag = 5'd30;
    tick();
    bus.enq_valid = 0; bus.commit_valid = 0;
    n_tests++; if (bus.mem_write !== 1'b1 || bus.count !== 3'd3) begin n_fail++; $display("FAIL flst_pre got wr=%b count=%0d exp 1/3", bus.mem_write, bus.count); end
    bus.flush = 1;
    tick();
    bus.flush = 0;
    n_tests++; if (bus.count !== 3'd1 || bus.mem_write !== 1'b1 || bus.mem_wdata !== 32'h11) begin n_fail++; $display("FAIL flst_keep got count=%0d wr=%b d=%h exp 1/1/11", bus.count, bus.mem_write, bus.mem_wdata); end
    bus.mem_hit = 1;
    tick();
    bus.mem_hit = 0;
    n_tests++; if (bus.count !== 3'd0 || bus.mem_write !== 1'b0) begin n_fail++; $display("FAIL flst_done got count=%0d wr=%b exp 0/0", bus.count, bus.mem_write); end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.mem_read !== 1'b0) stray++;
    end
    n_tests++; if (stray != 0) begin n_fail++; $display("FAIL flst_quiet got %0d read cycles exp=0", stray); end
  endtask

  task automatic test_reset_mid_access();
    set_enq(1, 3'b010, 32'h60, 32'h0, 32'h0, 5'd9);
    tick();
    bus.enq_valid = 0;
    tick();
    n_tests++; if (bus.mem_read !== 1'b1) begin n_fail++; $display("FAIL rma_pre got rd=%b exp=1", bus.mem_read); end
    #2 reset_n = 0;
    #1;
    n_tests++; if (bus.mem_read !== 1'b0 || bus.mem_addr !== 32'h0 || bus.count !== 3'd0) begin n_fail++; $display("FAIL rma_async got rd=%b a=%h count=%0d exp 0/0/0", bus.mem_read, bus.mem_addr, bus.count); end
    @(negedge clock);
    reset_n = 1;
    tick();
    tick();
    n_tests++; if (bus.mem_read !== 1'b0 || bus.wb_valid !== 1'b0) begin n_fail++; $display("FAIL rma_abandon got rd=%b v=%b exp 0/0", bus.mem_read, bus.wb_valid); end
  endtask

  initial begin
    test_reset();
    test_load_byte();
    test_load_retry();
    test_store_commit();
    test_full_wrap();
    test_wb_stall();
    test_flush_wb();
    test_flush_store();
    test_reset_mid_access();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
